// File: rtl/l2_tcdm_bank_xbar_if.sv
// l2_tcdm_bank_xbar_if: requestor-side and bank-side buses of the L2 TCDM bank crossbar.
interface l2_tcdm_bank_xbar_if #(
    parameter int NB_MASTERS      = 6,
    parameter int NB_BANKS        = 8,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int BANK_ADDR_WIDTH = 15
);
    logic [NB_MASTERS-1:0]                 m_req;
    logic [NB_MASTERS-1:0]                 m_gnt;
    logic [NB_MASTERS*ADDR_WIDTH-1:0]      m_add;
    logic [NB_MASTERS-1:0]                 m_wen;
    logic [NB_MASTERS*4-1:0]               m_be;
    logic [NB_MASTERS*DATA_WIDTH-1:0]      m_wdata;
    logic [NB_MASTERS-1:0]                 m_r_valid;
    logic [NB_MASTERS*DATA_WIDTH-1:0]      m_r_rdata;
    logic [NB_BANKS-1:0]                   b_req;
    logic [NB_BANKS-1:0]                   b_we;
    logic [NB_BANKS*BANK_ADDR_WIDTH-1:0]   b_add;
    logic [NB_BANKS*4-1:0]                 b_be;
    logic [NB_BANKS*DATA_WIDTH-1:0]        b_wdata;
    logic [NB_BANKS*DATA_WIDTH-1:0]        b_rdata;

    modport master (
        output m_req, m_add, m_wen, m_be, m_wdata, b_rdata,
        input  m_gnt, m_r_valid, m_r_rdata, b_req, b_we, b_add, b_be, b_wdata
    );

    modport slave (
        input  m_req, m_add, m_wen, m_be, m_wdata, b_rdata,
        output m_gnt, m_r_valid, m_r_rdata, b_req, b_we, b_add, b_be, b_wdata
    );
endinterface

// File: rtl/l2_tcdm_bank_xbar.sv
// l2_tcdm_bank_xbar: word-interleaved TCDM crossbar with per-bank round-robin and 1-cycle responses.
module l2_tcdm_bank_xbar #(
    parameter int NB_MASTERS      = 6,
    parameter int NB_BANKS        = 8,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int BANK_ADDR_WIDTH = 15
) (
    input logic                clk_i,
    input logic                rst_i,
    l2_tcdm_bank_xbar_if.slave bus
);
    localparam int BW = $clog2(NB_BANKS);
    localparam int MW = $clog2(NB_MASTERS);

    logic [BW-1:0]         tgt [NB_MASTERS];
    logic [MW-1:0]         rr_q [NB_BANKS];
    logic [MW-1:0]         win [NB_BANKS];
    logic [NB_BANKS-1:0]   win_vld;
    logic [NB_MASTERS-1:0] gnt;
    logic [NB_MASTERS-1:0] pend_q;
    logic [NB_MASTERS-1:0] rd_q;
    logic [BW-1:0]         bank_q [NB_MASTERS];
    logic                  unused_add;

    assign unused_add = ^bus.m_add;

    always_comb begin
        for (int m = 0; m < NB_MASTERS; m++) tgt[m] = bus.m_add[m*ADDR_WIDTH+2 +: BW];
    end

    // Scan from lowest to highest priority so the highest-priority requester is written last.
    always_comb begin
        int idx;
        idx = 0;
        win_vld = '0;
        for (int b = 0; b < NB_BANKS; b++) begin
            win[b] = '0;
            for (int i = NB_MASTERS - 1; i >= 0; i--) begin
                idx = int'(rr_q[b]) + i;
                if (idx >= NB_MASTERS) idx = idx - NB_MASTERS;
                if (bus.m_req[idx] && tgt[idx] == BW'(b)) begin
                    win_vld[b] = 1'b1;
                    win[b] = MW'(idx);
                end
            end
        end
    end

    always_comb begin
        for (int m = 0; m < NB_MASTERS; m++)
            gnt[m] = bus.m_req[m] && win_vld[tgt[m]] && win[tgt[m]] == MW'(m);
    end

    assign bus.m_gnt = gnt;
    assign bus.b_req = win_vld;

    always_comb begin
        bus.b_we    = '0;
        bus.b_add   = '0;
        bus.b_be    = '0;
        bus.b_wdata = '0;
        for (int b = 0; b < NB_BANKS; b++) begin
            bus.b_we[b] = win_vld[b] && !bus.m_wen[win[b]];
            bus.b_add[b*BANK_ADDR_WIDTH +: BANK_ADDR_WIDTH] = win_vld[b] ?
                bus.m_add[int'(win[b])*ADDR_WIDTH+2+BW +: BANK_ADDR_WIDTH] : '0;
            bus.b_be[b*4 +: 4] = win_vld[b] ? bus.m_be[int'(win[b])*4 +: 4] : '0;
            bus.b_wdata[b*DATA_WIDTH +: DATA_WIDTH] = win_vld[b] ?
                bus.m_wdata[int'(win[b])*DATA_WIDTH +: DATA_WIDTH] : '0;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < NB_BANKS; b++) begin
            if (rst_i) rr_q[b] <= '0;
            else if (win_vld[b]) rr_q[b] <= (win[b] == MW'(NB_MASTERS - 1)) ? '0 : win[b] + MW'(1);
        end
    end

    // A grant in the reset cycle still reaches the bank, but its response is dropped.
    always_ff @(posedge clk_i) begin
        pend_q <= rst_i ? '0 : gnt;
        for (int m = 0; m < NB_MASTERS; m++) begin
            if (gnt[m]) begin
                bank_q[m] <= tgt[m];
                rd_q[m]   <= bus.m_wen[m];
            end
        end
    end

    assign bus.m_r_valid = pend_q;

    always_comb begin
        bus.m_r_rdata = '0;
        for (int m = 0; m < NB_MASTERS; m++)
            bus.m_r_rdata[m*DATA_WIDTH +: DATA_WIDTH] = (pend_q[m] && rd_q[m]) ?
                bus.b_rdata[int'(bank_q[m])*DATA_WIDTH +: DATA_WIDTH] : '0;
    end
endmodule
